mult_operand_unpack_seq: RTL and testbench
==========================================

// Module: mult_operand_unpack_seq
// PURPOSE
//  Front end of the FP32 multiply path. Produces the raw operands that the
//  product normaliser consumes. Unpacks two IEEE-754 single operands into sign,
//  effective exponent and significand, and forms the biased exponent sum.
//  Builds the 48-bit significand product with an iterative shift-add datapath.
//  Output is a registered {sign, add_result, mult_result} word with valid/ready.
// PARAMETERS
//  BPC    2   multiplier bits retired per cycle; legal 1,2,3,4,6,8 (must divide 24)
//  BIAS   127 exponent bias subtracted from the exponent sum
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   operands a/b valid
//  in_ready     out  1   block can accept operands
//  a            in   32  IEEE-754 single operand A
//  b            in   32  IEEE-754 single operand B
//  out_valid    out  1   result valid; held until accepted
//  out_ready    in   1   downstream accepts result
//  sign         out  1   a[31]^b[31]
//  add_result   out  10  two's-complement biased exponent sum
//  mult_result  out  48  unsigned significand product {1.23} x {1.23}
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1, out_valid=0, sign=0, add_result=0, mult_result=0.
//  Unpack (on accept): exponent field==0 -> hidden bit 0, effective exp 1.
//   Otherwise hidden bit 1, effective exp = field. sig = {hidden, frac} (24b).
//   add_result = {2'b0,ea} + {2'b0,eb} - BIAS, 10-bit wrap-free (range -125..383).
//   Inf/NaN are not special-cased; they pass through as ordinary values.
//  FSM:
//   IDLE: in_ready=1. On in_valid&in_ready, latch operands.
//     If either sig==0 -> DONE, product 0.
//     Else -> MUL with acc=0, cnt=24/BPC.
//   MUL: in_ready=0. Each cycle: acc += sigA * mplr[BPC-1:0] << shift position.
//     Then shift the multiplier right by BPC and decrement cnt.
//     When cnt reaches 1, the final partial product is added and the state moves to DONE.
//   DONE: out_valid=1 with stable outputs. On out_ready -> IDLE.
//     in_ready stays 0 in DONE. There is no accept in the same cycle as output release.
//  Latency: accept edge to out_valid = 24/BPC+1 cycles (13 at BPC=2).
//   Zero-operand case: 1 cycle.
//  Throughput: one operation per 24/BPC+2 cycles minimum.
//  Outputs change only on the DONE entry edge. They hold while out_valid&!out_ready.
//  in_valid while busy is ignored (not queued). a/b are sampled only at accept.
//  Reset mid-MUL or mid-DONE: immediate abort to IDLE, outputs cleared, no output.
//  Product width: 24x24 fits 48 bits exactly; no truncation, no rounding here.
// CONFIGURATION
//  MULT_FTZ_EN defined: any operand with exponent field==0 is treated as zero.
//   Its significand is forced to 0 and the zero-skip path is taken.
//   add_result is still computed with effective exp 1.
//  MULT_FTZ_EN undefined: denormals are unpacked with hidden bit 0 and multiplied.
// TESTING
//  1) a=3F800000,b=3F800000 -> after 13 cyc: mult_result=48'h4000_0000_0000,
//     add_result=127, sign=0.
//  2) a=3FC00000,b=BFC00000 -> mult_result=48'h9000_0000_0000 (bit47=1),
//     add_result=127, sign=1.
//  3) a=00000001,b=3F800000 -> mult_result=48'h0000_0080_0000, add_result=1.
//     With MULT_FTZ_EN: mult_result=0, out_valid 1 cyc after accept.
//  4) a=00000000,b=40490FDB -> out_valid 1 cyc after accept, mult_result=0,
//     add_result=1+128-127=2.
//  5) Hold out_ready=0 for 5 cyc in DONE -> outputs stable, in_ready=0.
//     Then a new in_valid pulse in that window -> ignored.
//  6) Assert rst_n=0 at MUL cycle 6 -> out_valid=0, in_ready=1 asynchronously.
//     A fresh operation after release completes correctly.

Source files
------------

// File: rtl/mult_operand_unpack_seq.sv
// FP32 multiply front end: unpacks two singles, forms the biased exponent sum and
// a 48-bit significand product with an iterative shift-add loop. Option: MULT_FTZ_EN.
module mult_operand_unpack_seq #(
    parameter int BPC  = 2,
    parameter int BIAS = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [9:0]  add_result,
    output logic [47:0] mult_result
);

    localparam int          STEPS  = 24 / BPC;
    localparam int          CW     = $clog2(STEPS + 1);
    localparam logic [9:0]  BIAS_W = 10'(BIAS);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [47:0]   mcand_q;
    logic [23:0]   mplr_q;
    logic [47:0]   acc_q;
    logic          sign_hold_q;
    logic [9:0]    add_hold_q;
    logic          sign_q;
    logic [9:0]    add_q;
    logic [47:0]   mult_q;
    logic          out_valid_q;
    logic          in_ready_q;

    logic          hid_a, hid_b;
    logic [7:0]    ea_d, eb_d;
    logic [23:0]   sig_a_d, sig_b_d;
    logic [9:0]    add_d;
    logic          sign_d;
    logic          zero_d;
    logic [47:0]   pp_d;
    logic [47:0]   acc_d;

    // Denormals use effective exponent 1 whether or not they are flushed.
    always_comb begin
        hid_a  = |a[30:23];
        hid_b  = |b[30:23];
        ea_d   = hid_a ? a[30:23] : 8'd1;
        eb_d   = hid_b ? b[30:23] : 8'd1;
`ifdef MULT_FTZ_EN
        sig_a_d = hid_a ? {1'b1, a[22:0]} : 24'd0;
        sig_b_d = hid_b ? {1'b1, b[22:0]} : 24'd0;
`else
        sig_a_d = {hid_a, a[22:0]};
        sig_b_d = {hid_b, b[22:0]};
`endif
        add_d  = {2'b00, ea_d} + {2'b00, eb_d} - BIAS_W;
        sign_d = a[31] ^ b[31];
        zero_d = (sig_a_d == 24'd0) || (sig_b_d == 24'd0);
    end

    // One BPC-bit multiplier digit per cycle; mcand_q carries the shift position.
    always_comb begin
        pp_d = '0;
        for (int i = 0; i < BPC; i++) begin
            if (mplr_q[i]) pp_d = pp_d + (mcand_q << i);
        end
        acc_d = acc_q + pp_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            acc_q       <= '0;
            sign_hold_q <= 1'b0;
            add_hold_q  <= '0;
            sign_q      <= 1'b0;
            add_q       <= '0;
            mult_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        sign_hold_q <= sign_d;
                        add_hold_q  <= add_d;
                        in_ready_q  <= 1'b0;
                        if (zero_d) begin
                            state_q     <= S_DONE;
                            sign_q      <= sign_d;
                            add_q       <= add_d;
                            mult_q      <= '0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_MUL;
                            acc_q   <= '0;
                            mcand_q <= {24'd0, sig_a_d};
                            mplr_q  <= sig_b_d;
                            cnt_q   <= CW'(STEPS);
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == CW'(1)) begin
                        state_q     <= S_DONE;
                        mult_q      <= acc_d;
                        sign_q      <= sign_hold_q;
                        add_q       <= add_hold_q;
                        out_valid_q <= 1'b1;
                    end else begin
                        acc_q   <= acc_d;
                        mcand_q <= mcand_q << BPC;
                        mplr_q  <= mplr_q >> BPC;
                        cnt_q   <= cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign sign        = sign_q;
    assign add_result  = add_q;
    assign mult_result = mult_q;

endmodule

// File: tb/tb_mult_operand_unpack_seq.sv
// Directed bench for mult_operand_unpack_seq at BPC=2, BIAS=127.
module tb_mult_operand_unpack_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign;
    logic [9:0]  add_result;
    logic [47:0] mult_result;

    int n_tests = 0;
    int n_fail  = 0;

    mult_operand_unpack_seq #(.BPC(2), .BIAS(127)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sign(sign), .add_result(add_result), .mult_result(mult_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, check latency/results; optionally hold DONE with a stray in_valid pulse.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input int lat, input logic s, input logic [9:0] ad,
                          input logic [47:0] m, input int hold);
        int n;
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, " ready"}, in_ready, 1);
        a = ta; b = tb_v; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678;
        chk({tag, " busy"}, in_ready, 0);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " sign"}, sign, s);
        chk({tag, " add"}, add_result, ad);
        chk({tag, " mult"}, mult_result, m);
        for (int k = 0; k < hold; k++) begin
            in_valid = (k == 1);
            a = 32'h40000000; b = 32'h40400000;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({tag, " hold valid"}, out_valid, 1);
            chk({tag, " hold ready"}, in_ready, 0);
            chk({tag, " hold mult"}, mult_result, m);
            chk({tag, " hold add"}, add_result, ad);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " released"}, out_valid, 0);
        chk({tag, " idle ready"}, in_ready, 1);
        if (hold > 0) begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                chk({tag, " no ghost op"}, out_valid, 0);
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst sign", sign, 0);
        chk("rst add", add_result, 0);
        chk("rst mult", mult_result, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("one*one",   32'h3F800000, 32'h3F800000, 13, 1'b0, 10'd127, 48'h4000_0000_0000, 0);
        run_op("1.5*-1.5",  32'h3FC00000, 32'hBFC00000, 13, 1'b1, 10'd127, 48'h9000_0000_0000, 0);
`ifdef MULT_FTZ_EN
        run_op("denorm*1",  32'h00000001, 32'h3F800000, 1,  1'b0, 10'd1,   48'h0, 0);
        run_op("dn*dn",     32'h00000001, 32'h00000001, 1,  1'b0, 10'h383, 48'h0, 0);
`else
        run_op("denorm*1",  32'h00000001, 32'h3F800000, 13, 1'b0, 10'd1,   48'h0000_0080_0000, 0);
        run_op("dn*dn",     32'h00000001, 32'h00000001, 13, 1'b0, 10'h383, 48'h0000_0000_0001, 0);
`endif
        run_op("zero*pi",   32'h00000000, 32'h40490FDB, 1,  1'b0, 10'd2,   48'h0, 0);
        run_op("2*3",       32'h40000000, 32'h40400000, 13, 1'b0, 10'd129, 48'h6000_0000_0000, 0);
        run_op("max*max",   32'h7F7FFFFF, 32'hFF7FFFFF, 13, 1'b1, 10'd381, 48'hFFFF_FE00_0001, 0);
        run_op("inf*inf",   32'h7F800000, 32'h7F800000, 13, 1'b0, 10'd383, 48'h4000_0000_0000, 0);
        run_op("hold",      32'h3FC00000, 32'h3FC00000, 13, 1'b0, 10'd127, 48'h9000_0000_0000, 5);

        // Reset in the middle of a multiply must abort at once.
        a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort out_valid", out_valid, 0);
        chk("abort in_ready", in_ready, 1);
        chk("abort mult", mult_result, 0);
        chk("abort add", add_result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort no output", out_valid, 0);
        end
        run_op("after rst", 32'h40000000, 32'hC0400000, 13, 1'b1, 10'd129, 48'h6000_0000_0000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
